// File: rtl/io_timer.sv
// io_timer: memory-mapped countdown timer raising irq on expiry, one-shot or auto-reload.
// Define TIMER_IRQ_STATUS_EN to expose pending on CTRL bit4 and clear it by writing bit4=1.
module io_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  state_t      r_state;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_pending;
  logic        w_sel;
  logic        w_wr_ctrl;
  logic        w_wr_pre;
  logic        w_ctrl_upd;
  logic        w_stat;
  assign w_sel     = addr[29:2] == BASE_ADDR[31:4];
  assign w_wr_ctrl = we && w_sel && addr[1:0] == 2'd0;
  assign w_wr_pre  = we && w_sel && addr[1:0] == 2'd1;
`ifdef TIMER_IRQ_STATUS_EN
  assign w_ctrl_upd = w_wr_ctrl && !wdata[4];
  assign w_stat     = r_pending;
`else
  assign w_ctrl_upd = w_wr_ctrl;
  assign w_stat     = 1'b0;
`endif
  assign irq = r_ctrl[3] & r_pending;
  always_comb
    rdata = !w_sel           ? 32'h0 :
            addr[1:0] == 2'd0 ? {27'h0, w_stat, r_ctrl} :
            addr[1:0] == 2'd1 ? r_preset :
            addr[1:0] == 2'd2 ? r_count : 32'h0;
  // bus writes are placed after the FSM so they win over same-edge FSM updates
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ctrl    <= 4'h0;
      r_preset  <= 32'h0;
      r_count   <= 32'h0;
      r_pending <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (r_ctrl[0]) r_state <= LOAD;
        LOAD: begin
          r_count <= r_preset;
          r_state <= CNT;
        end
        CNT: begin
          if (!r_ctrl[0]) r_state <= IDLE;
          else if (r_count > 32'd1) r_count <= r_count - 32'd1;
          else begin
            r_count   <= 32'h0;
            r_pending <= 1'b1;
            r_state   <= INT;
          end
        end
        INT: begin
          if (r_ctrl[2:1] == 2'd1) begin
            r_pending <= 1'b0;
            r_state   <= LOAD;
          end else begin
            r_ctrl[0] <= 1'b0;
            r_state   <= IDLE;
          end
        end
      endcase
      if (w_ctrl_upd) r_ctrl <= wdata[3:0];
      if (w_wr_pre) r_preset <= wdata;
      if (w_wr_ctrl || w_wr_pre) r_pending <= 1'b0;
    end
  end
endmodule
